// File: rtl/jesd204b_cgs_rx_pkg.sv
// Shared types and constants for the JESD204B receive code-group synchronisation stage.
package jesd204b_cgs_pkg;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cgs_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;

  localparam int KCNT_SYNC    = 4;
  localparam int ICNT_LOSS    = 3;
  localparam int VCNT_RECOVER = 4;

  // A /K/ is a clean K28.5; anything with an error flag does not count.
  function automatic logic is_k28_5(input logic valid, input logic [7:0] data,
                                    input logic is_k, input logic disp_err,
                                    input logic nit_err);
    return valid && is_k && (data == K28_5) && !disp_err && !nit_err;
  endfunction

endpackage

// File: rtl/jesd204b_cgs_rx_if.sv
// Lane-side bundle of the CGS stage: decoded octets in, SYNC~ and forwarded octets out.
interface jesd204b_cgs_rx_if #(
  parameter int ERR_CNT_W = 16
);
  // in_valid / out_valid qualify one octet per cycle; there is no backpressure,
  // so the receiver of either stream must take every qualified octet.
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_is_k;
  logic                 in_disp_err;
  logic                 in_nit_err;
  logic                 sync_req;
  logic                 sync_n;
  logic [1:0]           cgs_state;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_is_k;
  logic                 out_sof;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_data, in_is_k, in_disp_err, in_nit_err, sync_req,
    input  sync_n, cgs_state, out_valid, out_data, out_is_k, out_sof, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_is_k, in_disp_err, in_nit_err, sync_req,
    output sync_n, cgs_state, out_valid, out_data, out_is_k, out_sof, err_cnt
  );
endinterface

// File: rtl/jesd204b_cgs_err_tracker.sv
// Invalid/valid code-group bookkeeping used while checking a synchronised lane.
module jesd204b_cgs_err_tracker
  import jesd204b_cgs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ok_stb,
  input  logic inv_stb,
  output logic loss,
  output logic recovered
);

  localparam logic [1:0] ICNT_LAST = 2'(ICNT_LOSS - 1);
  localparam logic [1:0] VCNT_LAST = 2'(VCNT_RECOVER - 1);

  logic [1:0] icnt_q;
  logic [1:0] vcnt_q;

  // Both flags describe what this cycle's strobe does to the counters.
  always_comb begin
    loss      = inv_stb && (icnt_q == ICNT_LAST);
    recovered = ok_stb && !inv_stb && (vcnt_q == VCNT_LAST) && (icnt_q == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      icnt_q <= '0;
      vcnt_q <= '0;
    end else if (inv_stb) begin
      icnt_q <= icnt_q + 2'd1;
      vcnt_q <= '0;
    end else if (ok_stb) begin
      if (vcnt_q == VCNT_LAST) begin
        vcnt_q <= '0;
        icnt_q <= icnt_q - 2'd1;
      end else begin
        vcnt_q <= vcnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/jesd204b_cgs_rx.sv
// Per-lane JESD204B CGS receiver: runs CS_INIT/CS_CHECK/CS_DATA, drives SYNC~
// and forwards octets with a start-of-data marker once synchronised.
module jesd204b_cgs_rx
  import jesd204b_cgs_pkg::*;
#(
  parameter int SYNC_MIN_CYCLES = 16,
  parameter int ERR_CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  jesd204b_cgs_rx_if.slave cgs_if
);

  localparam int              MIN_W    = (SYNC_MIN_CYCLES > 1) ? $clog2(SYNC_MIN_CYCLES) : 1;
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(SYNC_MIN_CYCLES - 1);
  localparam logic [2:0]      KCNT_MAX = 3'(KCNT_SYNC);

  cgs_state_e           state_q, state_d;
  logic [2:0]           kcnt_q, kcnt_d;
  logic [MIN_W-1:0]     mincnt_q, mincnt_d;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 sof_armed_q;
  logic                 sync_n_q, out_valid_q, out_is_k_q, out_sof_q;
  logic [7:0]           out_data_q;

  logic is_kchar, is_inv, is_ok, in_sync, fwd, sof_fire;
  logic loss, recovered;

  always_comb begin
    is_kchar = is_k28_5(cgs_if.in_valid, cgs_if.in_data, cgs_if.in_is_k,
                        cgs_if.in_disp_err, cgs_if.in_nit_err);
    is_inv   = cgs_if.in_valid && (cgs_if.in_disp_err || cgs_if.in_nit_err);
    is_ok    = cgs_if.in_valid && !is_inv;
    in_sync  = (state_q != CS_INIT);
    fwd      = cgs_if.in_valid && in_sync;
    sof_fire = fwd && sof_armed_q && !is_kchar;
  end

  jesd204b_cgs_err_tracker u_err_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_d == CS_INIT),
    .ok_stb    (is_ok && (state_q == CS_CHECK)),
    .inv_stb   (is_inv && in_sync),
    .loss      (loss),
    .recovered (recovered)
  );

  // sync_req outranks every octet-driven transition.
  always_comb begin
    state_d  = state_q;
    kcnt_d   = kcnt_q;
    mincnt_d = mincnt_q;
    if (cgs_if.sync_req) begin
      state_d = CS_INIT;
    end else if (cgs_if.in_valid) begin
      unique case (state_q)
        CS_INIT: begin
          kcnt_d   = is_kchar ? ((kcnt_q == KCNT_MAX) ? kcnt_q : kcnt_q + 3'd1) : 3'd0;
          mincnt_d = (mincnt_q == MIN_LAST) ? mincnt_q : mincnt_q + 1'b1;
          if ((kcnt_d == KCNT_MAX) && (mincnt_q == MIN_LAST)) state_d = CS_DATA;
        end
        CS_CHECK: begin
          if (loss)           state_d = CS_INIT;
          else if (recovered) state_d = CS_DATA;
        end
        CS_DATA: begin
          if (is_inv) state_d = CS_CHECK;
        end
        default: state_d = CS_INIT;
      endcase
    end
    if ((state_d == CS_INIT) && (cgs_if.sync_req || in_sync)) begin
      kcnt_d   = '0;
      mincnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CS_INIT;
      kcnt_q   <= '0;
      mincnt_q <= '0;
    end else begin
      state_q  <= state_d;
      kcnt_q   <= kcnt_d;
      mincnt_q <= mincnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q       <= '0;
      sof_armed_q <= 1'b1;
      sync_n_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_is_k_q  <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      if (is_inv && (err_q != '1)) err_q <= err_q + 1'b1;
      if (state_d == CS_INIT) sof_armed_q <= 1'b1;
      else if (sof_fire)      sof_armed_q <= 1'b0;
      sync_n_q    <= (state_d != CS_INIT);
      out_valid_q <= fwd;
      out_sof_q   <= sof_fire;
      if (fwd) begin
        out_data_q <= cgs_if.in_data;
        out_is_k_q <= cgs_if.in_is_k;
      end
    end
  end

  assign cgs_if.sync_n    = sync_n_q;
  assign cgs_if.cgs_state = state_q;
  assign cgs_if.out_valid = out_valid_q;
  assign cgs_if.out_data  = out_data_q;
  assign cgs_if.out_is_k  = out_is_k_q;
  assign cgs_if.out_sof   = out_sof_q;
  assign cgs_if.err_cnt   = err_q;

endmodule

// File: tb/tb_jesd204b_cgs_rx.sv
// Bench for jesd204b_cgs_rx: vector table, directed multi-cycle sequences and
// randomised traffic against a behavioural model with an expected-octet queue.
module tb_jesd204b_cgs_rx;
  import jesd204b_cgs_pkg::*;

  localparam int MINC = 16;
  localparam int EW   = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jesd204b_cgs_rx_if #(.ERR_CNT_W(EW)) bus ();

  jesd204b_cgs_rx #(.SYNC_MIN_CYCLES(MINC), .ERR_CNT_W(EW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cgs_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {sof, is_k, data} of each octet the model expects on the output
  logic [9:0] exp_q[$];

  // Reference model: lane state 0=init, 1=check, 2=data
  int m_state, m_k, m_min, m_i, m_v, m_err;
  bit m_arm;

  typedef struct {
    bit       v;
    bit [7:0] d;
    bit       k, de, ne, sr;
    int       st;
    bit       sn, ov, sof;
    int       err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_min = 0; m_i = 0; m_v = 0; m_err = 0; m_arm = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input bit [7:0] d, input bit k,
                            input bit de, input bit ne, input bit sr);
    bit inv, kc, sof;
    int nxt;
    inv = v && (de || ne);
    kc  = v && k && (d == K28_5) && !de && !ne;
    if (v && m_state != 0) begin
      sof = m_arm && !kc;
      exp_q.push_back({sof, k, d});
      if (sof) m_arm = 1'b0;
    end
    if (inv && m_err < EMAX) m_err++;
    nxt = m_state;
    if (sr) nxt = 0;
    else if (v) begin
      if (m_state == 0) begin
        m_k = kc ? ((m_k < 4) ? m_k + 1 : 4) : 0;
        if (m_k == 4 && m_min == MINC - 1) nxt = 2;
        if (m_min < MINC - 1) m_min++;
      end else if (m_state == 1) begin
        if (inv) begin
          m_i++; m_v = 0;
          if (m_i == 3) nxt = 0;
        end else begin
          m_v++;
          if (m_v == 4) begin
            m_v = 0; m_i--;
            if (m_i == 0) nxt = 2;
          end
        end
      end else if (inv) begin
        nxt = 1; m_i = 1; m_v = 0;
      end
    end
    if (nxt == 0 && (sr || m_state != 0)) begin
      m_k = 0; m_min = 0; m_i = 0; m_v = 0;
    end
    if (nxt == 0) m_arm = 1'b1;
    m_state = nxt;
  endtask

  task automatic compare_cycle();
    logic [9:0] e;
    check("sync_n", bus.sync_n, m_state != 0);
    check("cgs_state", bus.cgs_state, m_state);
    check("err_cnt", bus.err_cnt, m_err);
    check("out_valid", bus.out_valid, exp_q.size());
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.out_valid) check("out_octet", {bus.out_sof, bus.out_is_k, bus.out_data}, e);
    end else begin
      check("out_sof_idle", bus.out_sof, 1'b0);
    end
  endtask

  task automatic cyc(input bit v, input bit [7:0] d, input bit k,
                     input bit de, input bit ne, input bit sr);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_is_k     = k;
    bus.in_disp_err = de;
    bus.in_nit_err  = ne;
    bus.sync_req    = sr;
    @(posedge clk);
    #1;
    model_step(v, d, k, de, ne, sr);
    compare_cycle();
  endtask

  task automatic kchar();
    cyc(1'b1, K28_5, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_is_k     = 1'b0;
    bus.in_disp_err = 1'b0;
    bus.in_nit_err  = 1'b0;
    bus.sync_req    = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_sync_n", bus.sync_n, 1'b0);
    check("rst_state", bus.cgs_state, CS_INIT);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_is_k", bus.out_is_k, 1'b0);
    check("rst_out_sof", bus.out_sof, 1'b0);
    check("rst_err_cnt", bus.err_cnt, 0);
    rst_n = 1'b1;
  endtask

  function automatic void add(input bit v, input bit [7:0] d, input bit k, input bit de,
                              input bit ne, input bit sr, input int st, input bit sn,
                              input bit ov, input bit sof, input int err);
    vec_t t;
    t = '{v, d, k, de, ne, sr, st, sn, ov, sof, err};
    vecs.push_back(t);
  endfunction

  function automatic void add_sync(input int err);
    for (int i = 0; i < MINC; i++)
      add(1, K28_5, 1, 0, 0, 0, (i == MINC - 1) ? 2 : 0, i == MINC - 1, 0, 0, err);
  endfunction

  function automatic void build_table();
    add_sync(0);
    add(1, 8'h55, 0, 1, 0, 0, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 8'h10 + 8'(i), 0, 0, 0, 0, 1, 1, 1, 0, 1);
    add(0, 8'hEE, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 8'h20, 0, 0, 0, 0, 2, 1, 1, 0, 1);
    add(1, 8'h30, 0, 1, 0, 0, 1, 1, 1, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 8'h31 + 8'(i), 0, 0, 0, 0, 1, 1, 1, 0, 2);
    add(1, 8'h34, 0, 1, 0, 0, 1, 1, 1, 0, 3);
    add(1, 8'h35, 0, 0, 1, 0, 0, 0, 1, 0, 4);
    add_sync(4);
    add(1, 8'h40, 0, 0, 1, 0, 1, 1, 1, 1, 5);
    add(1, 8'h41, 0, 1, 0, 1, 0, 0, 1, 0, 6);
    add_sync(6);
    add(1, K28_5, 1, 0, 0, 0, 2, 1, 1, 0, 6);
    add(1, K28_5, 1, 0, 0, 0, 2, 1, 1, 0, 6);
    add(1, K28_0, 1, 0, 0, 0, 2, 1, 1, 1, 6);
    add(1, 8'h11, 0, 0, 0, 0, 2, 1, 1, 0, 6);
    add(1, 8'h22, 0, 0, 0, 0, 2, 1, 1, 0, 6);
  endfunction

  initial begin
    int       mode;
    bit       v, k, de, ne, sr;
    bit [7:0] d;

    do_reset();

    build_table();
    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].de, vecs[i].ne, vecs[i].sr);
      check($sformatf("vec%0d_state", i), bus.cgs_state, vecs[i].st);
      check($sformatf("vec%0d_sync_n", i), bus.sync_n, vecs[i].sn);
      check($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
      check($sformatf("vec%0d_out_sof", i), bus.out_sof, vecs[i].sof);
      check($sformatf("vec%0d_err_cnt", i), bus.err_cnt, vecs[i].err);
    end

    // A D0.0 among /K/s after mincnt is satisfied restarts the /K/ count
    cyc(1, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < MINC; i++) cyc(1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) kchar();
    check("kk_after_3k", bus.sync_n, 1'b0);
    cyc(1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      kchar();
      check($sformatf("kk_after_d0_k%0d", i + 1), bus.sync_n, 1'b0);
    end
    kchar();
    check("kk_sync_rise", bus.sync_n, 1'b1);
    check("kk_state_data", bus.cgs_state, CS_DATA);

    // Held sync_req pins CS_INIT and keeps mincnt cleared
    for (int i = 0; i < 20; i++) cyc(1, K28_5, 1, 0, 0, 1);
    check("hold_sr_state", bus.cgs_state, CS_INIT);
    for (int i = 0; i < MINC - 1; i++) kchar();
    check("hold_sr_min_low", bus.sync_n, 1'b0);
    kchar();
    check("hold_sr_release", bus.sync_n, 1'b1);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'hFF, 0, 0, 1, 0);
      if (i == EMAX - 1) check("err_at_max", bus.err_cnt, EMAX);
    end
    check("err_saturated", bus.err_cnt, EMAX);

    // Randomised traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      mode = (i / 48) % 3;
      v = ($urandom_range(0, 9) != 0);
      if (mode == 0 && $urandom_range(0, 9) != 0) begin
        d = K28_5;
        k = 1'b1;
      end else begin
        d = 8'($urandom_range(0, 255));
        k = ($urandom_range(0, 9) == 0);
        if (k && $urandom_range(0, 1) == 1) d = K28_0;
      end
      de = ($urandom_range(0, (mode == 2) ? 5 : 40) == 0);
      ne = ($urandom_range(0, (mode == 2) ? 7 : 60) == 0);
      sr = ($urandom_range(0, 299) == 0);
      cyc(v, d, k, de, ne, sr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
